// File: rtl/tilelink_ul_requester.sv
// TileLink-UL single-outstanding requester: turns one Get/Put command into an A beat,
// then forwards the D beats as responses, with timeout and illegal-command abort.
module tilelink_ul_requester #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_size,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_mask,
    output logic        channel_a_valid,
    input  logic        channel_a_ready,
    output logic [2:0]  channel_a_bits_opcode,
    output logic [2:0]  channel_a_bits_param,
    output logic [3:0]  channel_a_bits_size,
    output logic        channel_a_bits_source,
    output logic [31:0] channel_a_bits_address,
    output logic [3:0]  channel_a_bits_mask,
    output logic [31:0] channel_a_bits_data,
    input  logic        channel_d_valid,
    output logic        channel_d_ready,
    input  logic [2:0]  channel_d_bits_opcode,
    input  logic [1:0]  channel_d_bits_param,
    input  logic [3:0]  channel_d_bits_size,
    input  logic        channel_d_bits_source,
    input  logic        channel_d_bits_sink,
    input  logic [31:0] channel_d_bits_data,
    input  logic        channel_d_bits_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_error,
    output logic        busy
);

    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP, ABORT} state_e;

    state_e        state_q;
    logic [2:0]    beat_q;
    logic [TW-1:0] tmo_q;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [3:0]    size_q;
    logic [31:0]   data_q;
    logic [3:0]    mask_q;

    function automatic logic [3:0] get_mask(input logic [1:0] a, input logic [3:0] s);
        if (s >= 4'd2)      return 4'hF;
        else if (s == 4'd1) return a[1] ? 4'hC : 4'h3;
        else                return 4'h1 << a;
    endfunction

    // Lane-0 aligned byte pattern of a full transfer of the given size.
    function automatic logic [3:0] full_mask(input logic [3:0] s);
        if (s == 4'd0)      return 4'h1;
        else if (s == 4'd1) return 4'h3;
        else                return 4'hF;
    endfunction

    function automatic logic [2:0] last_idx(input logic wr, input logic [3:0] s);
        if (wr)             return 3'd0;
        else if (s == 4'd3) return 3'd1;
        else if (s == 4'd4) return 3'd3;
        else                return 3'd0;
    endfunction

    logic in_idle, in_req, in_resp, in_abort;
    logic illegal, cmd_fire, d_fire, is_last, tmo_hit, exp_d_op;

    assign in_idle  = (state_q == IDLE);
    assign in_req   = (state_q == REQ);
    assign in_resp  = (state_q == RESP);
    assign in_abort = (state_q == ABORT);

    assign illegal  = (cmd_write && (cmd_size > 4'd2)) || (cmd_size > 4'd4);
    assign cmd_fire = in_idle && cmd_valid;
    assign d_fire   = in_resp && channel_d_valid && rsp_ready;
    assign is_last  = (beat_q == last_idx(write_q, size_q));
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
    assign exp_d_op = ~write_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q  <= 3'd0;
            tmo_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (cmd_valid) state_q <= illegal ? ABORT : REQ;
                REQ: begin
                    if (channel_a_ready) begin
                        state_q <= RESP;
                        beat_q  <= 3'd0;
                        tmo_q   <= '0;
                    end
                end
                RESP: begin
                    if (d_fire) begin
                        tmo_q <= '0;
                        if (is_last) state_q <= IDLE;
                        else         beat_q  <= beat_q + 3'd1;
                    end else if (tmo_hit) begin
                        state_q <= ABORT;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ABORT: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Command fields carry no reset; they are only meaningful after a handshake.
    always_ff @(posedge clock) begin
        if (cmd_fire) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            size_q  <= cmd_size;
            data_q  <= cmd_data;
            mask_q  <= cmd_mask;
        end
    end

    assign cmd_ready = in_idle;
    assign busy      = !in_idle;

    assign channel_a_valid        = in_req;
    assign channel_a_bits_opcode  = !in_req ? 3'd0 :
                                    !write_q ? 3'd4 :
                                    (mask_q == full_mask(size_q)) ? 3'd0 : 3'd1;
    assign channel_a_bits_param   = 3'd0;
    assign channel_a_bits_source  = 1'b0;
    assign channel_a_bits_size    = in_req ? size_q : 4'd0;
    assign channel_a_bits_address = in_req ? addr_q : 32'd0;
    assign channel_a_bits_mask    = !in_req ? 4'd0 : write_q ? mask_q : get_mask(addr_q[1:0], size_q);
    assign channel_a_bits_data    = (in_req && write_q) ? data_q : 32'd0;

    assign channel_d_ready = in_resp && rsp_ready;
    assign rsp_valid       = in_resp ? channel_d_valid : in_abort;
    assign rsp_data        = in_resp ? channel_d_bits_data : 32'd0;
    assign rsp_last        = in_resp ? is_last : in_abort;
    assign rsp_error       = in_resp ? (channel_d_bits_error ||
                                        (channel_d_bits_opcode != {2'b00, exp_d_op}) ||
                                        channel_d_bits_source)
                                     : in_abort;

    logic unused_d;
    assign unused_d = ^{channel_d_bits_param, channel_d_bits_size, channel_d_bits_sink};

endmodule

// File: tb/tb_tilelink_ul_requester.sv
// Directed bench for tilelink_ul_requester: scoreboard of expected responses,
// popped and compared on every rsp handshake.
module tb_tilelink_ul_requester;

    localparam int TMO = 20;

    logic        clock, reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_data;
    logic [3:0]  cmd_size, cmd_mask;
    logic        channel_a_valid, channel_a_ready;
    logic [2:0]  channel_a_bits_opcode, channel_a_bits_param;
    logic [3:0]  channel_a_bits_size, channel_a_bits_mask;
    logic        channel_a_bits_source;
    logic [31:0] channel_a_bits_address, channel_a_bits_data;
    logic        channel_d_valid, channel_d_ready;
    logic [2:0]  channel_d_bits_opcode;
    logic [1:0]  channel_d_bits_param;
    logic [3:0]  channel_d_bits_size;
    logic        channel_d_bits_source, channel_d_bits_sink, channel_d_bits_error;
    logic [31:0] channel_d_bits_data;
    logic        rsp_valid, rsp_ready, rsp_last, rsp_error, busy;
    logic [31:0] rsp_data;

    tilelink_ul_requester #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .channel_a_valid(channel_a_valid), .channel_a_ready(channel_a_ready),
        .channel_a_bits_opcode(channel_a_bits_opcode), .channel_a_bits_param(channel_a_bits_param),
        .channel_a_bits_size(channel_a_bits_size), .channel_a_bits_source(channel_a_bits_source),
        .channel_a_bits_address(channel_a_bits_address), .channel_a_bits_mask(channel_a_bits_mask),
        .channel_a_bits_data(channel_a_bits_data),
        .channel_d_valid(channel_d_valid), .channel_d_ready(channel_d_ready),
        .channel_d_bits_opcode(channel_d_bits_opcode), .channel_d_bits_param(channel_d_bits_param),
        .channel_d_bits_size(channel_d_bits_size), .channel_d_bits_source(channel_d_bits_source),
        .channel_d_bits_sink(channel_d_bits_sink), .channel_d_bits_data(channel_d_bits_data),
        .channel_d_bits_error(channel_d_bits_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_error(rsp_error), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   a_fires = 0;
    bit   a_seen, cmd_fired, fired;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Sample on the falling edge, return just after the rising edge.
    task automatic tick();
        rsp_t e;
        @(negedge clock);
        if (cmd_valid && cmd_ready) cmd_fired = 1'b1;
        if (channel_a_valid) a_seen = 1'b1;
        if (channel_a_valid && channel_a_ready) a_fires++;
        fired = rsp_valid && rsp_ready;
        if (fired) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_last", 32'(rsp_last), 32'(e.last));
                chk("rsp_error", 32'(rsp_error), 32'(e.err));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] size,
                            input logic [31:0] data, input logic [3:0] mask);
        cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_data = data; cmd_mask = mask;
        cmd_valid = 1'b1;
        cmd_fired = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("cmd_accept", 32'(cmd_fired), 32'd1);
    endtask

    task automatic check_a(input logic [2:0] op, input logic [3:0] mask,
                           input logic [31:0] addr, input logic [3:0] size);
        chk("a_valid", 32'(channel_a_valid), 32'd1);
        chk("a_opcode", 32'(channel_a_bits_opcode), 32'(op));
        chk("a_mask", 32'(channel_a_bits_mask), 32'(mask));
        chk("a_address", channel_a_bits_address, addr);
        chk("a_size", 32'(channel_a_bits_size), 32'(size));
        chk("a_param_source", 32'({channel_a_bits_param, channel_a_bits_source}), 32'd0);
    endtask

    task automatic a_handshake();
        int n0;
        n0 = a_fires;
        channel_a_ready = 1'b1;
        tick();
        channel_a_ready = 1'b0;
        chk("a_fire", 32'(a_fires - n0), 32'd1);
    endtask

    task automatic d_beat(input logic [31:0] data, input logic [2:0] op, input logic derr,
                          input logic exp_last, input logic exp_err, input bit toggle);
        exp_q.push_back('{data: data, last: exp_last, err: exp_err});
        channel_d_valid = 1'b1;
        channel_d_bits_data = data;
        channel_d_bits_opcode = op;
        channel_d_bits_error = derr;
        fired = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (toggle) rsp_ready = ~rsp_ready;
            if (fired) break;
        end
        channel_d_valid = 1'b0;
        channel_d_bits_error = 1'b0;
        chk("d_beat_accepted", 32'(fired), 32'd1);
    endtask

    initial begin
        int waited;
        reset_n = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_data = 0; cmd_mask = 0;
        channel_a_ready = 0; channel_d_valid = 0; channel_d_bits_opcode = 0;
        channel_d_bits_param = 0; channel_d_bits_size = 0; channel_d_bits_source = 0;
        channel_d_bits_sink = 0; channel_d_bits_data = 0; channel_d_bits_error = 0;
        rsp_ready = 0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_outputs", 32'({busy, channel_a_valid, channel_d_ready, rsp_valid, rsp_last, rsp_error}), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        tick(); tick();
        reset_n = 1'b1;

        // Single-beat Get, D beats ignored while in REQ
        send_cmd(1'b0, 32'h10, 4'd2, 32'h0, 4'h0);
        check_a(3'd4, 4'hF, 32'h10, 4'd2);
        channel_d_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("req_d_ready", 32'(channel_d_ready), 32'd0);
        chk("req_rsp_valid", 32'(rsp_valid), 32'd0);
        channel_d_valid = 1'b0;
        tick();
        chk("a_hold_stable", channel_a_bits_address, 32'h10);
        a_handshake();
        chk("resp_busy", 32'(busy), 32'd1);
        d_beat(32'hDEADBEEF, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle_after_get", 32'(cmd_ready), 32'd1);

        // Four-beat Get with rsp_ready toggling; a_ready high during the cmd cycle
        channel_a_ready = 1'b1;
        rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h100, 4'd4, 32'h0, 4'h0);
        check_a(3'd4, 4'hF, 32'h100, 4'd4);
        a_handshake();
        for (int i = 0; i < 4; i++)
            d_beat(32'h1000 + 32'(i), 3'd1, 1'b0, (i == 3), 1'b0, 1'b1);
        chk("idle_after_burst", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;

        // Partial Put, full Put with wrong D opcode, Get with denied
        send_cmd(1'b1, 32'h3, 4'd0, 32'hAB000000, 4'h8);
        check_a(3'd1, 4'h8, 32'h3, 4'd0);
        chk("a_data", channel_a_bits_data, 32'hAB000000);
        a_handshake();
        d_beat(32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        send_cmd(1'b1, 32'h20, 4'd2, 32'h12345678, 4'hF);
        check_a(3'd0, 4'hF, 32'h20, 4'd2);
        a_handshake();
        d_beat(32'h0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);

        send_cmd(1'b0, 32'h6, 4'd1, 32'h0, 4'h0);
        check_a(3'd4, 4'hC, 32'h6, 4'd1);
        a_handshake();
        d_beat(32'h5555, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Timeout with no D response
        send_cmd(1'b0, 32'h40, 4'd2, 32'h0, 4'h0);
        a_handshake();
        exp_q.push_back('{data: 32'h0, last: 1'b1, err: 1'b1});
        waited = 0;
        fired = 1'b0;
        for (int i = 0; i < 3 * TMO; i++) begin
            tick();
            if (fired) break;
            waited++;
        end
        chk("timeout_cycles", 32'(waited), 32'(TMO));
        chk("idle_after_timeout", 32'(cmd_ready), 32'd1);

        // Illegal Put size 3 and Get size 5 go straight to abort
        rsp_ready = 1'b0;
        a_seen = 1'b0;
        send_cmd(1'b1, 32'h0, 4'd3, 32'h0, 4'hF);
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("abort_last_err", 32'({rsp_last, rsp_error}), 32'd3);
        chk("abort_data", rsp_data, 32'd0);
        chk("abort_d_ready", 32'(channel_d_ready), 32'd0);
        exp_q.push_back('{data: 32'h0, last: 1'b1, err: 1'b1});
        rsp_ready = 1'b1;
        tick();
        chk("abort_fired", 32'(fired), 32'd1);
        send_cmd(1'b0, 32'h0, 4'd5, 32'h0, 4'h0);
        exp_q.push_back('{data: 32'h0, last: 1'b1, err: 1'b1});
        tick();
        chk("abort5_fired", 32'(fired), 32'd1);
        chk("illegal_no_a_valid", 32'(a_seen), 32'd0);

        // Asynchronous reset in the middle of a four-beat Get
        send_cmd(1'b0, 32'h200, 4'd4, 32'h0, 4'h0);
        a_handshake();
        d_beat(32'hA0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        d_beat(32'hA1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        channel_d_valid = 1'b1;
        channel_d_bits_data = 32'hA2;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst_d_ready", 32'(channel_d_ready), 32'd0);
        tick(); tick();
        channel_d_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        send_cmd(1'b0, 32'h300, 4'd2, 32'h0, 4'h0);
        check_a(3'd4, 4'hF, 32'h300, 4'd2);
        a_handshake();
        d_beat(32'hCAFEF00D, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
